// File: rtl/regfile_writeback_ctrl.sv
// Register file write side: ALU/load writeback arbitration, registered write port, busy scoreboard.
// Optional macro WB_BYPASS_EN: clear busy on the accept edge and expose rf_wdata forwarding hits.
module regfile_writeback_ctrl #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              issue_valid,
    input  logic [REG_AW-1:0] issue_rd,
    output logic              issue_ready,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    output logic              rs1_busy,
    output logic              rs2_busy,
    input  logic              alu_valid,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    output logic              alu_ready,
    input  logic              ld_valid,
    input  logic [REG_AW-1:0] ld_rd,
    input  logic [XLEN-1:0]   ld_data,
    output logic              ld_ready,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_rd,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              wb_err,
    output logic              rs1_fwd_hit,
    output logic              rs2_fwd_hit
);
    localparam int NREG = 1 << REG_AW;

    logic [NREG-1:0]   r_busy;
    logic              r_ld_last;   // 1: load won the most recent tie
    logic              r_we;
    logic [REG_AW-1:0] r_rd;
    logic [XLEN-1:0]   r_wdata;
    logic              r_err;

    logic              w_acc;
    logic [REG_AW-1:0] w_rd;
    logic [XLEN-1:0]   w_data;
    logic [NREG-1:0]   w_set;
    logic [NREG-1:0]   w_clr;
    logic [NREG-1:0]   w_busy_nxt;

    // A lone valid source always wins; on a tie the source that lost last time wins.
    assign alu_ready = alu_valid && (!ld_valid || r_ld_last);
    assign ld_ready  = ld_valid && (!alu_valid || !r_ld_last);
    assign w_acc     = alu_ready || ld_ready;
    assign w_rd      = alu_ready ? alu_rd : ld_rd;
    assign w_data    = alu_ready ? alu_data : ld_data;

    assign issue_ready = (issue_rd == '0) || !r_busy[issue_rd];
    assign rs1_busy    = r_busy[rs1];
    assign rs2_busy    = r_busy[rs2];

`ifdef WB_BYPASS_EN
    assign rs1_fwd_hit = r_we && (r_rd == rs1) && (rs1 != '0);
    assign rs2_fwd_hit = r_we && (r_rd == rs2) && (rs2 != '0);
`else
    assign rs1_fwd_hit = 1'b0;
    assign rs2_fwd_hit = 1'b0;
`endif

    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (issue_valid && issue_ready && (issue_rd != '0))
            w_set[issue_rd] = 1'b1;
`ifdef WB_BYPASS_EN
        if (w_acc)
            w_clr[w_rd] = 1'b1;
`else
        if (r_we)
            w_clr[r_rd] = 1'b1;
`endif
        // Set after clear so a same-edge issue keeps the register busy; x0 never busy.
        w_busy_nxt = ((r_busy & ~w_clr) | w_set) & {{(NREG-1){1'b1}}, 1'b0};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy    <= '0;
            r_ld_last <= 1'b1;
            r_we      <= 1'b0;
            r_rd      <= '0;
            r_wdata   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_we   <= w_acc && (w_rd != '0);
            if (w_acc) begin
                r_rd    <= w_rd;
                r_wdata <= w_data;
                if ((w_rd != '0) && !r_busy[w_rd])
                    r_err <= 1'b1;
            end
            if (alu_valid && ld_valid)
                r_ld_last <= ld_ready;
        end
    end

    assign rf_we    = r_we;
    assign rf_rd    = r_rd;
    assign rf_wdata = r_wdata;
    assign wb_err   = r_err;
endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// Directed + randomized bench for regfile_writeback_ctrl against a spec-level scoreboard model.
module tb_regfile_writeback_ctrl;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        issue_valid, issue_ready;
    logic [4:0]  issue_rd, rs1, rs2;
    logic        rs1_busy, rs2_busy;
    logic        alu_valid, alu_ready, ld_valid, ld_ready;
    logic [4:0]  alu_rd, ld_rd;
    logic [31:0] alu_data, ld_data;
    logic        rf_we, wb_err, rs1_fwd_hit, rs2_fwd_hit;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;

    regfile_writeback_ctrl #(.XLEN(32), .REG_AW(5)) dut (
        .clk(clk), .reset_n(reset_n),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .wb_err(wb_err),
        .rs1_fwd_hit(rs1_fwd_hit), .rs2_fwd_hit(rs2_fwd_hit)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    // Reference model state
    bit          m_busy [32];
    bit          m_ld_last;
    bit          m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_wdata;
    bit          m_err;
    bit          acc_alu, acc_ld, e_ir;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_ld_last = 1'b1;
        m_we = 1'b0; m_rd = '0; m_wdata = '0; m_err = 1'b0;
    endtask

    task automatic check_all();
        bit f1, f2;
        e_ir = (issue_rd == 0) || !m_busy[issue_rd];
        if (alu_valid && ld_valid) begin
            acc_alu = m_ld_last;
            acc_ld  = !m_ld_last;
        end else begin
            acc_alu = alu_valid;
            acc_ld  = ld_valid;
        end
        f1 = BYP && m_we && (m_rd == rs1) && (rs1 != 0);
        f2 = BYP && m_we && (m_rd == rs2) && (rs2 != 0);
        chk("issue_ready", issue_ready, e_ir);
        chk("rs1_busy", rs1_busy, m_busy[rs1]);
        chk("rs2_busy", rs2_busy, m_busy[rs2]);
        chk("alu_ready", alu_ready, acc_alu);
        chk("ld_ready", ld_ready, acc_ld);
        chk("rf_we", rf_we, m_we);
        chk("rf_rd", rf_rd, m_rd);
        chk("rf_wdata", rf_wdata, m_wdata);
        chk("wb_err", wb_err, m_err);
        chk("rs1_fwd_hit", rs1_fwd_hit, f1);
        chk("rs2_fwd_hit", rs2_fwd_hit, f2);
    endtask

    task automatic model_update();
        bit          win, old_we;
        logic [4:0]  wrd, old_rd;
        logic [31:0] wd;
        old_we = m_we;
        old_rd = m_rd;
        win = acc_alu || acc_ld;
        wrd = acc_alu ? alu_rd : ld_rd;
        wd  = acc_alu ? alu_data : ld_data;
        if (win) begin
            if (wrd != 0 && !m_busy[wrd]) m_err = 1'b1;
            m_we = (wrd != 0);
            m_rd = wrd;
            m_wdata = wd;
        end else begin
            m_we = 1'b0;
        end
        if (BYP) begin
            if (win) m_busy[wrd] = 1'b0;
        end else if (old_we) begin
            m_busy[old_rd] = 1'b0;
        end
        if (issue_valid && e_ir && issue_rd != 0) m_busy[issue_rd] = 1'b1;
        m_busy[0] = 1'b0;
        if (alu_valid && ld_valid) m_ld_last = acc_ld;
    endtask

    task automatic tick();
        @(negedge clk);
        check_all();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 0; alu_valid = 0; ld_valid = 0;
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        issue_rd = 0; rs1 = 0; rs2 = 0; alu_rd = 0; ld_rd = 0; alu_data = 0; ld_data = 0;
        idle();
        model_reset();
        // Reset held with random inputs: state stays cleared
        for (int i = 0; i < 4; i++) begin
            issue_valid = 1'($urandom); issue_rd = 5'($urandom);
            alu_valid = 1'($urandom); alu_rd = 5'($urandom); alu_data = $urandom;
            ld_valid = 1'($urandom); ld_rd = 5'($urandom); ld_data = $urandom;
            rs1 = 5'($urandom); rs2 = 5'($urandom);
            @(negedge clk);
            chk("rst_rf_we", rf_we, 0);
            chk("rst_rf_rd", rf_rd, 0);
            chk("rst_rf_wdata", rf_wdata, 0);
            chk("rst_wb_err", wb_err, 0);
            chk("rst_rs1_busy", rs1_busy, 0);
            chk("rst_rs2_busy", rs2_busy, 0);
            chk("rst_issue_ready", issue_ready, 1);
            @(posedge clk); #1;
        end
        idle();
        reset_n = 1'b1;
        issue_rd = 5; rs1 = 5; rs2 = 0;
        tick();

        // Issue x5, ALU writeback three cycles later
        issue_valid = 1; issue_rd = 5; tick();
        issue_valid = 0; tick(); tick(); tick();
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF; tick();
        alu_valid = 0;
        chk("x5_we", rf_we, 1);
        chk("x5_rd", rf_rd, 5);
        chk("x5_data", rf_wdata, 32'hDEADBEEF);
        chk("x5_busy_after_acc", rs1_busy, !BYP);
        tick();
        chk("x5_busy_cleared", rs1_busy, 0);
        chk("x5_we_idle", rf_we, 0);

        // Round-robin ties
        for (int rep = 0; rep < 2; rep++) begin
            issue_valid = 1; issue_rd = 3; tick();
            issue_rd = 4; tick();
            issue_valid = 0;
            alu_valid = 1; alu_rd = 3; alu_data = 32'hA000_0000 + rep;
            ld_valid = 1; ld_rd = 4; ld_data = 32'hB000_0000 + rep;
            tick();
            chk("tie_first_rd", rf_rd, rep == 0 ? 3 : 4);
            if (acc_alu) alu_valid = 0;
            if (acc_ld) ld_valid = 0;
            tick();
            chk("tie_second_rd", rf_rd, rep == 0 ? 4 : 3);
            alu_valid = 0; ld_valid = 0;
            tick(); tick();
        end

        // WAW stall on x7
        issue_valid = 1; issue_rd = 7; tick();
        chk("x7_second_blocked", issue_ready, 0);
        tick();
        alu_valid = 1; alu_rd = 7; alu_data = 32'h7777; tick();
        alu_valid = 0;
        n = 0;
        while (!e_ir && n < 10) begin tick(); n++; end
        chk("x7_reissue_bound", (n < 10), 1);
        issue_valid = 0; rs1 = 7;
        #1;
        chk("x7_busy_after_reissue", rs1_busy, 1);
        tick();
        alu_valid = 1; alu_rd = 7; alu_data = 32'h7778; tick();
        alu_valid = 0; tick(); tick();

        // x0 writeback, then unexpected writeback to idle x9
        alu_valid = 1; alu_rd = 0; alu_data = 32'h1234; tick();
        alu_valid = 0;
        chk("x0_acc", acc_alu, 1);
        chk("x0_no_we", rf_we, 0);
        chk("x0_no_err", wb_err, 0);
        ld_valid = 1; ld_rd = 9; ld_data = 32'h9999; tick();
        ld_valid = 0;
        chk("x9_err", wb_err, 1);
        tick(); tick();
        chk("x9_err_sticky", wb_err, 1);

        // Forwarding window for x2
        issue_valid = 1; issue_rd = 2; tick();
        issue_valid = 0; rs1 = 2;
        alu_valid = 1; alu_rd = 2; alu_data = 32'h55; tick();
        alu_valid = 0;
        #1;
        chk("x2_busy", rs1_busy, !BYP);
        chk("x2_fwd", rs1_fwd_hit, BYP);
        chk("x2_wdata", rf_wdata, 32'h55);
        tick();

        // Reset mid-operation drops pending state
        issue_valid = 1; issue_rd = 6; tick();
        alu_valid = 1; alu_rd = 6; alu_data = 32'h66;
        reset_n = 0; #1;
        model_reset();
        chk("mid_rst_err", wb_err, 0);
        chk("mid_rst_we", rf_we, 0);
        idle(); tick();
        reset_n = 1; tick();

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            issue_valid = 1'($urandom);
            issue_rd = 5'($urandom_range(0, 7));
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
            if (!alu_valid && ($urandom % 3 == 0)) begin
                alu_valid = 1; alu_rd = 5'($urandom_range(0, 7)); alu_data = $urandom;
            end
            if (!ld_valid && ($urandom % 3 == 0)) begin
                ld_valid = 1; ld_rd = 5'($urandom_range(0, 7)); ld_data = $urandom;
            end
            tick();
            if (acc_alu) alu_valid = 0;
            if (acc_ld) ld_valid = 0;
        end
        idle(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
